servo_seq_ctrl: RTL and testbench



---
 rtl/servo_seq_ctrl_pkg.sv | 23 ++
 rtl/servo_seq_ctrl_if.sv | 19 +
 rtl/servo_seq_ctrl_debounce.sv | 58 +++++
 rtl/servo_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_servo_seq_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/servo_seq_ctrl_pkg.sv
// Shared definitions for the servo command path.
// The pulse generator reuses the same selection codes.
//   state_t   : sequencer states
//   SEL_*     : width-select codes driven on sel
//   cnt_width : counter width for a counter that must hold 0..limit-1
package servo_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        POS_MAX = 2'd1,
        POS_MID = 2'd2,
        RETURN  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_1MS   = 2'd0;
    localparam logic [1:0] SEL_2MS   = 2'd1;
    localparam logic [1:0] SEL_1P5MS = 2'd2;

    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/servo_seq_ctrl_if.sv
// Command/status bundle between the motor-test logic and servo_seq_ctrl.
//   btn  : raw push button, active high, asynchronous
//   stop : synchronous abort, active high
//   sel  : width select to the pulse generator
//   busy : sequence running
//   done : one-cycle pulse on normal completion
// master = command side, slave = servo_seq_ctrl.
interface servo_seq_ctrl_if;

    logic       btn;
    logic       stop;
    logic [1:0] sel;
    logic       busy;
    logic       done;

    modport master (output btn, stop, input sel, busy, done);
    modport slave  (input btn, stop, output sel, busy, done);

endinterface

// File: rtl/servo_seq_ctrl_debounce.sv
// Button conditioner: two-flop synchronizer plus tick-based stability counter.
//   clk, rst_n : clock, synchronous active-low reset
//   i_btn      : raw button
//   i_tick     : 1 ms tick strobe
//   o_press    : one-cycle pulse on a debounced 0->1 transition
module btn_debounce
    import servo_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    input  logic i_tick,
    output logic o_press
);

    localparam int unsigned     SW        = cnt_width(DEBOUNCE_MS);
    localparam logic [SW-1:0]   STAB_LAST = SW'(DEBOUNCE_MS - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic [SW-1:0] r_stab;
    logic          w_accept;

    // Accepting on the tick that would take the count to DEBOUNCE_MS keeps
    // the counter inside its own width.
    assign w_accept = (r_sync2 != r_level) && i_tick && (r_stab == STAB_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_stab  <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= w_accept && r_sync2;
            if (r_sync2 == r_level) begin
                r_stab <= '0;
            end else if (i_tick) begin
                if (r_stab == STAB_LAST) begin
                    r_level <= r_sync2;
                    r_stab  <= '0;
                end else begin
                    r_stab <= r_stab + 1'b1;
                end
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/servo_seq_ctrl.sv
// Servo command sequencer: on each debounced press steps sel through
// 2 ms -> 1.5 ms -> 1 ms, holding each position HOLD_MS ticks.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of servo_seq_ctrl_if (btn, stop in; sel, busy, done out)
// Parameters: TICK_DIV clk cycles per tick, DEBOUNCE_MS and HOLD_MS in ticks.
module servo_seq_ctrl
    import servo_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 50000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned HOLD_MS     = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    servo_seq_ctrl_if.slave    bus
);

    localparam int unsigned   TW        = cnt_width(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam int unsigned   HW        = cnt_width(HOLD_MS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MS - 1);

    logic [TW-1:0] r_tick_cnt;
    logic [HW-1:0] r_hold_cnt;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_sel;
    logic          r_busy;
    logic          r_done;
    logic [1:0]    w_sel_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;
    logic          w_tick;
    logic          w_press;
    logic          w_hold_done;

    // Free-running prescaler, never realigned to the sequence.
    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    btn_debounce #(
        .DEBOUNCE_MS (DEBOUNCE_MS)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (bus.btn),
        .i_tick  (w_tick),
        .o_press (w_press)
    );

    assign w_hold_done = w_tick && (r_hold_cnt == HOLD_LAST);

    // State register, hold counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_sel      <= SEL_1MS;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            if (w_state_nxt != r_state) begin
                r_hold_cnt <= '0;
            end else if ((r_state != IDLE) && w_tick) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    // Next state; stop overrides everything, including a coincident press.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.stop) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_press)     w_state_nxt = POS_MAX;
                POS_MAX: if (w_hold_done) w_state_nxt = POS_MID;
                POS_MID: if (w_hold_done) w_state_nxt = RETURN;
                RETURN:  if (w_hold_done) w_state_nxt = IDLE;
                default:                  w_state_nxt = IDLE;
            endcase
        end
    end

    // Outputs decoded from the next state so they land on the same edge.
    always_comb begin
        w_sel_nxt  = SEL_1MS;
        w_busy_nxt = 1'b0;
        w_done_nxt = (r_state == RETURN) && (w_state_nxt == IDLE) && !bus.stop;
        case (w_state_nxt)
            POS_MAX: begin
                w_sel_nxt  = SEL_2MS;
                w_busy_nxt = 1'b1;
            end
            POS_MID: begin
                w_sel_nxt  = SEL_1P5MS;
                w_busy_nxt = 1'b1;
            end
            RETURN: begin
                w_sel_nxt  = SEL_1MS;
                w_busy_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.sel  = r_sel;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_servo_seq_ctrl.sv
// Directed bench for servo_seq_ctrl with TICK_DIV=10, DEBOUNCE_MS=3, HOLD_MS=5.
module tb_servo_seq_ctrl;
    import servo_pkg::*;

    localparam int unsigned TDIV = 10;
    localparam int unsigned DEB  = 3;
    localparam int unsigned HOLD = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec    = 0;
    int   n_miss   = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    servo_seq_ctrl_if bus();

    servo_seq_ctrl #(
        .TICK_DIV    (TDIV),
        .DEBOUNCE_MS (DEB),
        .HOLD_MS     (HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Negedges until sel reaches v, bounded by budget.
    task automatic wait_sel(input logic [1:0] v, input int budget, output int n);
        n = 0;
        while (bus.sel !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Number of cycles sel stays at v, starting from a cycle where it already is v.
    task automatic dwell(input logic [1:0] v, input int budget, output int n);
        n = 0;
        while (bus.sel === v && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Called at the first cycle of POS_MAX; follows the sequence to its end.
    task automatic run_seq(input string tag, input bit press_mid);
        int n;
        int d0;
        d0 = done_cnt;
        dwell(SEL_2MS, 100, n);
        $display("info %s: POS_MAX dwell %0d cycles", tag, n);
        chk({tag, "_max_len_in_41_50"}, (n >= 41 && n <= 50), 1);
        chk({tag, "_mid_sel"}, bus.sel, SEL_1P5MS);
        chk({tag, "_mid_busy"}, bus.busy, 1);
        if (press_mid) begin
            fork
                begin
                    bus.btn = 1'b1;
                    tick_n(45);
                    bus.btn = 1'b0;
                end
            join_none
        end
        dwell(SEL_1P5MS, 100, n);
        chk({tag, "_mid_len"}, n, 50);
        chk({tag, "_ret_sel"}, bus.sel, SEL_1MS);
        chk({tag, "_ret_busy"}, bus.busy, 1);
        n = 0;
        while (bus.sel === SEL_1MS && bus.busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ret_len"}, n, 50);
        chk({tag, "_end_busy"}, bus.busy, 0);
        chk({tag, "_done_hi"}, bus.done, 1);
        @(negedge clk);
        chk({tag, "_done_lo"}, bus.done, 0);
        chk({tag, "_done_once"}, done_cnt - d0, 1);
    endtask

    initial begin
        int n;
        int bad;
        int d0;

        // Reset held with the button already pressed.
        bus.btn  = 1'b1;
        bus.stop = 1'b0;
        rst_n    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_sel", bus.sel, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
        end
        rst_n = 1'b1;
        fork
            begin
                tick_n(60);
                bus.btn = 1'b0;
            end
        join_none
        wait_sel(SEL_2MS, 60, n);
        $display("info rst: press-to-sel latency %0d cycles", n);
        chk("rst_press_lat_in_23_34", (n >= 23 && n <= 34), 1);
        chk("rst_start_busy", bus.busy, 1);
        run_seq("clean", 1'b0);

        tick_n(60);
        chk("idle_sel", bus.sel, 0);
        chk("idle_busy", bus.busy, 0);

        // Bouncing button: every level lasts only 7 cycles.
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (i % 7 == 0) bus.btn = ~bus.btn;
            @(negedge clk);
            if (bus.sel !== SEL_1MS || bus.busy !== 1'b0) bad++;
        end
        bus.btn = 1'b0;
        tick_n(50);
        if (bus.sel !== SEL_1MS || bus.busy !== 1'b0) bad++;
        chk("bounce_idle_cycles_bad", bad, 0);

        // Second press arriving during POS_MID.
        bus.btn = 1'b1;
        fork
            begin
                tick_n(40);
                bus.btn = 1'b0;
            end
        join_none
        wait_sel(SEL_2MS, 60, n);
        chk("busy_press_lat_in_23_34", (n >= 23 && n <= 34), 1);
        run_seq("busy", 1'b1);
        d0  = done_cnt;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.sel !== SEL_1MS || bus.busy !== 1'b0) bad++;
        end
        chk("busy_no_restart_bad", bad, 0);
        chk("busy_no_extra_done", done_cnt - d0, 0);

        // Stop held in IDLE across an accepted press: press is discarded.
        bus.stop = 1'b1;
        bus.btn  = 1'b1;
        bad = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (bus.sel !== SEL_1MS || bus.busy !== 1'b0) bad++;
        end
        bus.btn = 1'b0;
        tick_n(5);
        bus.stop = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.sel !== SEL_1MS || bus.busy !== 1'b0) bad++;
        end
        chk("stop_press_discard_bad", bad, 0);

        // Stop during POS_MID.
        bus.btn = 1'b1;
        fork
            begin
                tick_n(40);
                bus.btn = 1'b0;
            end
        join_none
        wait_sel(SEL_2MS, 60, n);
        chk("stop_run_lat_in_23_34", (n >= 23 && n <= 34), 1);
        wait_sel(SEL_1P5MS, 60, n);
        chk("stop_reach_mid", bus.sel, SEL_1P5MS);
        tick_n(10);
        d0 = done_cnt;
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("stop_sel", bus.sel, 0);
        chk("stop_busy", bus.busy, 0);
        chk("stop_done", bus.done, 0);
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.sel !== SEL_1MS || bus.busy !== 1'b0) bad++;
        end
        chk("stop_stays_idle_bad", bad, 0);
        chk("stop_no_done", done_cnt - d0, 0);

        // New press after stop restarts at 2 ms, then reset inside POS_MAX.
        bus.btn = 1'b1;
        wait_sel(SEL_2MS, 60, n);
        chk("restart_lat_in_23_34", (n >= 23 && n <= 34), 1);
        chk("restart_busy", bus.busy, 1);
        tick_n(5);
        chk("restart_still_max", bus.sel, SEL_2MS);
        d0      = done_cnt;
        bus.btn = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_sel", bus.sel, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.sel !== SEL_1MS || bus.busy !== 1'b0) bad++;
        end
        chk("midrst_no_press_bad", bad, 0);
        chk("midrst_no_done", done_cnt - d0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got %0d vectors, expected completion", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
